// File: rtl/spike_packetizer_if.sv
// Packet stream handshake between the spike packetizer and its consumer.
// The master drives data/valid; the slave answers with ready.
interface spike_packetizer_if;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;

    modport master (
        output pkt_data,
        output pkt_valid,
        input  pkt_ready
    );

    modport slave (
        input  pkt_data,
        input  pkt_valid,
        output pkt_ready
    );
endinterface

// File: rtl/spike_packetizer.sv
// Collects one-cycle neuron spikes into a pending bitmap and serialises them
// as timestamped 32-bit packets using a round-robin arbiter.
module spike_packetizer #(
    parameter int NUM_NEURONS     = 35,
    parameter int TIMESTAMP_WIDTH = 16,
    parameter int NEURON_ID_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_NEURONS-1:0] neuron_spikes,
    input  logic                   tick,
    spike_packetizer_if.master     pkt,
    output logic                   busy,
    output logic [15:0]            drop_count,
    output logic                   overflow
);

    localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int PW = $clog2(NUM_NEURONS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

    logic [NUM_NEURONS-1:0]     pending;
    logic [IW-1:0]              last_grant;
    logic [TIMESTAMP_WIDTH-1:0] timestamp;
    logic [31:0]                data_q;
    logic                       valid_q;

    logic [NUM_NEURONS-1:0] above;
    logic [NUM_NEURONS-1:0] grant_mask;
    logic [NUM_NEURONS-1:0] drops;
    logic [NUM_NEURONS-1:0] next_pending;
    logic [IW-1:0]          hi_idx;
    logic [IW-1:0]          lo_idx;
    logic [IW-1:0]          grant_idx;
    logic                   hi_any;
    logic                   lo_any;
    logic                   free;
    logic                   do_grant;
    logic                   eop;
    logic [PW-1:0]          drop_n;
    logic [16:0]            drop_sum;
    logic [15:0]            drop_next;
    logic [31:0]            pkt_next;

    assign free = !valid_q || pkt.pkt_ready;

    // Neurons strictly after the last grant are searched first; the plain
    // lowest-index pick over all pending bits provides the wrap-around.
    always_comb begin
        above  = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            above[i] = (IW'(i) > last_grant);
        end
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_any = 1'b1;
                lo_idx = IW'(i);
                if (above[i]) begin
                    hi_any = 1'b1;
                    hi_idx = IW'(i);
                end
            end
        end
    end

    assign grant_idx = hi_any ? hi_idx : lo_idx;
    assign do_grant  = free && lo_any;

    always_comb begin
        grant_mask = '0;
        if (do_grant) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    // A spike landing on a still-pending, ungranted neuron is lost.
    assign drops        = neuron_spikes & pending & ~grant_mask;
    assign next_pending = (pending & ~grant_mask) | neuron_spikes;
    assign eop          = (next_pending == '0);

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            drop_n = drop_n + PW'(drops[i]);
        end
    end

    assign drop_sum  = {1'b0, drop_count} + 17'(drop_n);
    assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    assign pkt_next = {
        timestamp,
        NEURON_ID_WIDTH'(grant_idx),
        1'b1,
        eop
    };

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending    <= '0;
            last_grant <= LAST_IDX;
            timestamp  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            pending    <= next_pending;
            drop_count <= drop_next;
            if (tick) begin
                timestamp <= timestamp + 1'b1;
            end
            if (|drops) begin
                overflow <= 1'b1;
            end
            if (free) begin
                if (lo_any) begin
                    data_q     <= pkt_next;
                    valid_q    <= 1'b1;
                    last_grant <= grant_idx;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign pkt.pkt_data  = data_q;
    assign pkt.pkt_valid = valid_q;
    assign busy          = (|pending) || valid_q;

endmodule

// File: tb/tb_spike_packetizer.sv
// Self-checking bench: vector table for single spikes, scoreboard queue for
// every accepted packet, and hand-written multi-cycle corner sequences.
module tb_spike_packetizer;
    localparam int NN = 35;

    logic          clk;
    logic          rst;
    logic [NN-1:0] neuron_spikes;
    logic          tick;
    logic          busy;
    logic [15:0]   drop_count;
    logic          overflow;

    spike_packetizer_if pif ();

    spike_packetizer #(
        .NUM_NEURONS(NN),
        .TIMESTAMP_WIDTH(16),
        .NEURON_ID_WIDTH(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .neuron_spikes(neuron_spikes),
        .tick(tick),
        .pkt(pif),
        .busy(busy),
        .drop_count(drop_count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        int          id;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[5];

    function automatic logic [31:0] mk(input logic [15:0] ts, input int id,
                                       input logic e);
        mk = {ts, 14'(id), 1'b1, e};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 300) begin
            step();
            k++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_busy_low", 32'(busy), 32'd0);
    endtask

    // Scoreboard: every handshake must match the next expected packet.
    always @(negedge clk) begin
        if (rst && pif.pkt_valid && pif.pkt_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pkt actual=%h required=none",
                         pif.pkt_data);
            end else begin
                chk("pkt_data", pif.pkt_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        vt[0] = '{5,  32'h0000_0017};
        vt[1] = '{0,  32'h0000_0003};
        vt[2] = '{17, 32'h0000_0047};
        vt[3] = '{1,  32'h0000_0007};
        vt[4] = '{34, 32'h0000_008B};

        rst = 1'b0;
        neuron_spikes = '0;
        tick = 1'b0;
        pif.pkt_ready = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(pif.pkt_valid), 32'd0);
        chk("rst_data", pif.pkt_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;
        step();

        // Single spikes with fixed latency at timestamp 0.
        for (int i = 0; i < 5; i++) begin
            neuron_spikes = NN'(1) << vt[i].id;
            exp_q.push_back(vt[i].exp);
            step();
            neuron_spikes = '0;
            chk("lat_not_yet", 32'(pif.pkt_valid), 32'd0);
            step();
            chk("lat_valid", 32'(pif.pkt_valid), 32'd1);
            chk("lat_data", pif.pkt_data, vt[i].exp);
            drain();
        end

        // Burst 0,3,34 back to back; eop only on the last.
        neuron_spikes = '0;
        neuron_spikes[0] = 1'b1;
        neuron_spikes[3] = 1'b1;
        neuron_spikes[34] = 1'b1;
        exp_q.push_back(mk(16'h0, 0, 1'b0));
        exp_q.push_back(mk(16'h0, 3, 1'b0));
        exp_q.push_back(mk(16'h0, 34, 1'b1));
        step();
        neuron_spikes = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("burst_valid", 32'(pif.pkt_valid), 32'd1);
        end
        step();
        chk("burst_busy", 32'(busy), 32'd0);
        drain();

        // Backpressure holds id 1 steady for ten cycles.
        pif.pkt_ready = 1'b0;
        neuron_spikes = '0;
        neuron_spikes[1] = 1'b1;
        neuron_spikes[2] = 1'b1;
        step();
        neuron_spikes = '0;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_data", pif.pkt_data, mk(16'h0, 1, 1'b0));
            chk("bp_hold_valid", 32'(pif.pkt_valid), 32'd1);
            step();
        end
        exp_q.push_back(mk(16'h0, 1, 1'b0));
        exp_q.push_back(mk(16'h0, 2, 1'b1));
        pif.pkt_ready = 1'b1;
        drain();

        // Round-robin wrap: last grant is 2, so 30 precedes 1.
        neuron_spikes = '0;
        neuron_spikes[1] = 1'b1;
        neuron_spikes[30] = 1'b1;
        exp_q.push_back(mk(16'h0, 30, 1'b0));
        exp_q.push_back(mk(16'h0, 1, 1'b1));
        step();
        neuron_spikes = '0;
        drain();

        // Collision behind a held packet: two drops, one id-7 packet.
        pif.pkt_ready = 1'b0;
        neuron_spikes = NN'(1) << 3;
        step();
        neuron_spikes = '0;
        step();
        for (int i = 0; i < 3; i++) begin
            neuron_spikes = NN'(1) << 7;
            step();
            neuron_spikes = '0;
            step();
        end
        chk("col_drop", 32'(drop_count), 32'd2);
        chk("col_ovf", 32'(overflow), 32'd1);
        chk("col_hold", pif.pkt_data, mk(16'h0, 3, 1'b1));
        exp_q.push_back(mk(16'h0, 3, 1'b1));
        exp_q.push_back(mk(16'h0, 7, 1'b1));
        pif.pkt_ready = 1'b1;
        drain();
        chk("col_ovf_sticky", 32'(overflow), 32'd1);
        chk("col_drop_keep", 32'(drop_count), 32'd2);

        // Tick coinciding with the load edge uses the pre-increment value.
        tick = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tick = 1'b0;
        neuron_spikes = NN'(1) << 9;
        step();
        neuron_spikes = '0;
        tick = 1'b1;
        exp_q.push_back(mk(16'h3, 9, 1'b1));
        step();
        tick = 1'b0;
        drain();

        // Counter now 4; walk it to FFFF, then across the wrap.
        tick = 1'b1;
        for (int i = 0; i < 65531; i++) step();
        tick = 1'b0;
        neuron_spikes = NN'(1) << 12;
        exp_q.push_back(mk(16'hFFFF, 12, 1'b1));
        step();
        neuron_spikes = '0;
        drain();
        tick = 1'b1;
        step();
        tick = 1'b0;
        neuron_spikes = NN'(1) << 13;
        exp_q.push_back(mk(16'h0000, 13, 1'b1));
        step();
        neuron_spikes = '0;
        drain();

        // Reset mid-transfer with four spikes still pending.
        tick = 1'b1;
        step();
        step();
        tick = 1'b0;
        pif.pkt_ready = 1'b0;
        neuron_spikes = NN'(5'b11111);
        step();
        neuron_spikes = '0;
        step();
        chk("mid_valid_pre", 32'(pif.pkt_valid), 32'd1);
        rst = 1'b0;
        neuron_spikes = '1;
        tick = 1'b1;
        step();
        chk("mid_valid", 32'(pif.pkt_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_drop", 32'(drop_count), 32'd0);
        chk("mid_ovf", 32'(overflow), 32'd0);
        step();
        rst = 1'b1;
        neuron_spikes = '0;
        tick = 1'b0;
        pif.pkt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_idle", 32'(pif.pkt_valid), 32'd0);
        end
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Arbiter pointer and timestamp both restart from reset.
        neuron_spikes = '0;
        neuron_spikes[0] = 1'b1;
        neuron_spikes[34] = 1'b1;
        exp_q.push_back(mk(16'h0, 0, 1'b0));
        exp_q.push_back(mk(16'h0, 34, 1'b1));
        step();
        neuron_spikes = '0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
